// File: rtl/dp_ram_fifo_ctrl_if.sv
// Streaming handshake bundle for the RAM-backed FIFO controller.
// slave: the controller (accepts upstream words, offers downstream words).
// master: the environment that feeds and drains it.
interface dp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller over a dual-port RAM (port A writes, port B reads).
// The RAM's registered read is hidden behind a 2-entry output buffer so both
// sides stream one word per cycle.
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dp_ram_fifo_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_wrA,
  output logic [ADDR_WIDTH-1:0] ram_addrA,
  output logic [DATA_WIDTH-1:0] ram_dataA_in,
  output logic                  ram_wrB,
  output logic [ADDR_WIDTH-1:0] ram_addrB,
  output logic [DATA_WIDTH-1:0] ram_dataB_in,
  input  logic [DATA_WIDTH-1:0] ram_dataB_out
);
  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;   // words in RAM not yet fetched
  logic                  pending;     // fetch issued last cycle, data lands now
  logic [1:0]            ob_count;
  logic [DATA_WIDTH-1:0] ob0, ob1;    // ob0 is the head
  logic                  push, pop, fetch;
  logic [2:0]            ob_after;    // buffer demand after this cycle's pop
  logic [1:0]            ob_count_n;
  logic [DATA_WIDTH-1:0] ob0_n, ob1_n;

  assign bus.s_ready  = !rst && (mem_count < DEPTH_C);
  assign bus.m_valid  = (ob_count != 2'd0);
  assign bus.m_data   = ob0;
  assign push         = bus.s_valid && bus.s_ready;
  assign pop          = bus.m_valid && bus.m_ready;
  // Only fetch when the landing word is guaranteed a free buffer slot.
  assign ob_after     = {1'b0, ob_count} + {2'b0, pending} - {2'b0, pop};
  assign fetch        = (mem_count != '0) && (ob_after <= 3'd1);

  assign ram_wrA      = push;
  assign ram_addrA    = wr_ptr;
  assign ram_dataA_in = bus.s_data;
  assign ram_wrB      = 1'b0;
  assign ram_addrB    = rd_ptr;
  assign ram_dataB_in = '0;

  assign count = (ADDR_WIDTH+2)'(mem_count) + (ADDR_WIDTH+2)'(pending)
               + (ADDR_WIDTH+2)'(ob_count);

  // Output buffer next state: pop shifts first, then a landing word fills the tail.
  always_comb begin
    ob0_n      = ob0;
    ob1_n      = ob1;
    ob_count_n = ob_count;
    if (pop) begin
      ob0_n      = ob1;
      ob_count_n = ob_count_n - 2'd1;
    end
    if (pending) begin
      if (ob_count_n == 2'd0) ob0_n = ram_dataB_out;
      else                    ob1_n = ram_dataB_out;
      ob_count_n = ob_count_n + 2'd1;
    end
  end

  // Pointers, RAM occupancy, in-flight flag and output buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      pending   <= 1'b0;
      ob_count  <= '0;
      ob0       <= '0;
      ob1       <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fetch})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
      pending  <= fetch;
      ob_count <= ob_count_n;
      ob0      <= ob0_n;
      ob1      <= ob1_n;
    end
  end
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: a behavioural dual-port RAM, a scoreboard
// monitor on the falling edge, and one task per scenario.
module tb_dp_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+1:0] count;
  logic          ram_wrA, ram_wrB;
  logic [AW-1:0] ram_addrA, ram_addrB;
  logic [DW-1:0] ram_dataA_in, ram_dataB_in, ram_dataB_out;
  logic [DW-1:0] mem [2**AW];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  dp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  dp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count),
    .ram_wrA(ram_wrA), .ram_addrA(ram_addrA), .ram_dataA_in(ram_dataA_in),
    .ram_wrB(ram_wrB), .ram_addrB(ram_addrB), .ram_dataB_in(ram_dataB_in),
    .ram_dataB_out(ram_dataB_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: port A writes, port B registered read.
  always @(posedge clk) begin
    if (ram_wrA) mem[ram_addrA] <= ram_dataA_in;
    if (ram_wrB) mem[ram_addrB] <= ram_dataB_in;
    ram_dataB_out <= mem[ram_addrB];
  end

  // Scoreboard monitor: occupancy, ordering, stall stability, port-B tie-off.
  always @(negedge clk) begin
    logic [DW-1:0] exp;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      n_tests++;
      if (count !== AW'(0) + 6'(q.size())) begin
        n_fail++; $display("FAIL count: got %0d expected %0d", count, q.size());
      end
      n_tests++;
      if (ram_wrB !== 1'b0 || ram_dataB_in !== '0) begin
        n_fail++; $display("FAIL port_b_tie: got wrB=%b dataB_in=%0h expected 0/0", ram_wrB, ram_dataB_in);
      end
      if (prev_stall) begin
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%0h expected v=1 d=%0h", bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL sb_pop: got word %0h expected no output", bus.m_data);
        end else begin
          exp = q.pop_front();
          if (bus.m_data !== exp) begin
            n_fail++; $display("FAIL sb_data: got %0h expected %0h", bus.m_data, exp);
          end
        end
      end
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) q.push_back(bus.s_data);
      prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
      prev_data  = bus.m_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
      step();
      n_tests++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || count !== '0 ||
          ram_wrA !== 1'b0 || bus.s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got v=%b d=%0h cnt=%0d wrA=%b rdy=%b expected 0 0 0 0 0",
                 bus.m_valid, bus.m_data, count, ram_wrA, bus.s_ready);
      end
    end
    rst = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.s_ready);
    end
    step();
  endtask

  task automatic test_single_word();
    bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.m_ready = 1'b1;
    #1;
    n_tests++;
    if (ram_wrA !== 1'b1 || ram_addrA !== 4'd0) begin
      n_fail++; $display("FAIL single_write: got wrA=%b addrA=%0d expected 1 0", ram_wrA, ram_addrA);
    end
    step();
    bus.s_valid = 1'b0;
    step(); step();
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5) begin
      n_fail++; $display("FAIL single_out: got v=%b d=%0h expected v=1 d=a5", bus.m_valid, bus.m_data);
    end
    step();
    n_tests++;
    if (bus.m_valid !== 1'b0 || count !== '0) begin
      n_fail++; $display("FAIL single_empty: got v=%b cnt=%0d expected 0 0", bus.m_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(i);
      #1;
      n_tests++;
      if (bus.s_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_ready word %0d: got %b expected 1", i, bus.s_ready);
      end
      step();
    end
    bus.s_data = 8'h12;
    #1;
    n_tests++;
    if (bus.s_ready !== 1'b0 || count !== 6'd18 || ram_wrA !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got rdy=%b cnt=%0d wrA=%b expected 0 18 0", bus.s_ready, count, ram_wrA);
    end
    step();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain word %0d: got v=%b d=%0h expected v=1 d=%0h", i, bus.m_valid, bus.m_data, i);
      end
      step();
    end
    n_tests++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got v=%b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_streaming();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      bus.s_valid = (c < 100);
      bus.s_data  = 8'(c);
      #1;
      if (c >= 3 && c < 103) begin
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(c - 3)) begin
          n_fail++;
          $display("FAIL stream cycle %0d: got v=%b d=%0h expected v=1 d=%0h", c, bus.m_valid, bus.m_data, 8'(c - 3));
        end
      end
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_random_backpressure();
    for (int c = 0; c < 2000; c++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
      step();
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    for (int c = 0; c < 40; c++) step();
    n_tests++;
    if (q.size() != 0 || bus.m_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL random_drain: got left=%0d v=%b cnt=%0d expected 0 0 0", q.size(), bus.m_valid, count);
    end
  endtask

  task automatic test_reset_occupied();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(8'h50 + i);
      step();
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0; rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 6'd5 || bus.m_valid !== 1'b1) begin
      n_fail++; $display("FAIL occupied_pre: got cnt=%0d v=%b expected 5 1", count, bus.m_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (count !== '0 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL occupied_reset: got cnt=%0d v=%b expected 0 0", count, bus.m_valid);
    end
    bus.s_valid = 1'b1; bus.s_data = 8'h3C; bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    step(); step();
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h3C) begin
      n_fail++; $display("FAIL post_reset_word: got v=%b d=%0h expected v=1 d=3c", bus.m_valid, bus.m_data);
    end
    step();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_single_word();
    test_fill_drain();
    test_streaming();
    test_random_backpressure();
    test_reset_occupied();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
